handshake_sync_sink: RTL
========================

Name: handshake_sync_sink

Overview:
- Clocked consumer placed directly downstream of the asynchronous bundled-data ring stages.
- Accepts the ring's 2-phase request/data output (r_i, d_i) and returns its acknowledge (a_o).
- Brings each token into the clock domain, buffers it in a small FIFO, and presents it as a valid/ready stream to synchronous logic.
- Withholds acknowledge when the FIFO is full, so the async ring stalls instead of losing tokens.

Parameters:
- N, 8, data width; matches the ring data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flops in the r_i synchronizer; at least 2.
- CW, 16, width of the token counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; shared name with the async stages.
- r_i  in  1  2-phase request from upstream; each transition marks one new token.
- d_i  in  N  bundled data; stable from the r_i transition until the matching a_o transition.
- a_o  out  1  2-phase acknowledge to upstream; toggles once per accepted token.
- m_valid  out  1  FIFO head is valid.
- m_data  out  N  FIFO head data.
- m_ready  in  1  downstream consumer accepts the head.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- count  out  CW  total tokens accepted since reset, mod 2^CW.

Behaviour:
- Reset: asserting rst at a clock edge clears the following.
  - Synchronizer flops to 0.
  - a_o = 0, count = 0, level = 0.
  - m_valid = 0; m_data holds its previous value (don't-care).
  - FIFO pointers to 0.
  - rst must be asserted in the same window as the upstream ring's rst, so both sides restart at phase 0.
- Synchronizer: r_i feeds SYNC_STAGES flops; the last stage is req_s.
  - r_i is never used combinationally. d_i is never synchronized.
- Pending token: pending = req_s XOR a_o.
- Accept condition: accept = pending AND (level < DEPTH OR (m_valid AND m_ready)).
- On a clock edge with accept = 1:
  - Write d_i into the FIFO at the write pointer.
  - Toggle a_o and increment count (wrapping at 2^CW).
  - d_i is guaranteed stable here because the sender holds data until a_o toggles.
- Latency: an r_i transition first sampled at edge k gives:
  - req_s updated at edge k+SYNC_STAGES-1;
  - accept, a_o toggle and FIFO write at edge k+SYNC_STAGES;
  - m_valid = 1 after that edge when the FIFO was empty (first-word fall-through, no extra cycle).
- Throughput: at most one token per handshake round trip (upstream response time plus SYNC_STAGES+1 cycles).
  - No second token can be pending before a_o toggles, so no token is ever dropped.
- Pop: on a clock edge with m_valid AND m_ready, advance the read pointer.
  - m_data always shows the entry at the read pointer. m_data and m_valid are stable while m_valid=1 and m_ready=0.
- Occupancy update:
  - push only: level +1.
  - pop only: level -1.
  - push and pop in the same cycle: level unchanged.
- Full: when level = DEPTH and no pop occurs, pending stays high and a_o does not toggle.
  - Upstream stalls. Acceptance resumes on the first edge with a pop, or the edge after level drops.
- Empty: m_valid = 0 and m_ready is ignored. level never underflows.
- Pointers wrap modulo DEPTH. level uses one extra bit so that full is distinct from empty.
- r_i already at 1 on reset release: treated as a pending token and accepted normally after synchronization.
- rst mid-operation overrides any accept or pop in that cycle. FIFO contents are discarded.
- a_o is a registered output, so it is glitch-free.

Test Plan:
- Reset, then one r_i toggle 0→1 with d_i=0x5A sampled at edge k -> a_o toggles to 1 at edge k+2 (SYNC_STAGES=2); m_valid=1 and m_data=0x5A after that edge; count=1.
- Drive a behavioural model of the 2-phase ring producing 0x01,0x02,0x03…, with m_ready held 1 -> 100 tokens arrive in order with none missing; count=100; level never exceeds 1.
- m_ready held 0 with 6 tokens offered, DEPTH=4:
  - 4 accepted, level=4, a_o frozen after the 4th toggle.
  - Raise m_ready for one cycle: 5th token accepted on that edge, level stays 4.
- Level = DEPTH, pending token present, and m_ready=1 in the same cycle -> simultaneous push and pop; level stays 4; FIFO order preserved (head = oldest token).
- Force count to 0xFFFF via 65535 accepted tokens, then accept one more -> count wraps to 0x0000; data path unaffected.
- rst asserted while level=3 and a token is pending -> the next edge gives level=0, m_valid=0, a_o=0, count=0; after release, a fresh r_i toggle is accepted as normal.

Source files
------------

// File: rtl/handshake_sync_sink.sv
`default_nettype none
// ============================================================================
// Module   : handshake_sync_sink
// Brief    : 2-phase bundled-data sink that synchronizes each request, stores
//            the token in a fall-through FIFO and presents it as valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_sync_sink #(
    parameter int N           = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_i,
    input  logic [N-1:0]             d_i,
    output logic                     a_o,
    output logic                     m_valid,
    output logic [N-1:0]             m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ack;
    logic [CW-1:0]          r_count;
    logic [LW-1:0]          r_level;
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [N-1:0]           r_mem [DEPTH];

    logic w_req_s;
    logic w_pending;
    logic w_pop;
    logic w_accept;

    assign w_req_s   = r_sync[SYNC_STAGES-1];
    assign w_pending = w_req_s ^ r_ack;
    assign m_valid   = (r_level != '0);
    assign w_pop     = m_valid & m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_accept  = w_pending & ((r_level < LEVEL_FULL) | w_pop);

    assign a_o    = r_ack;
    assign level  = r_level;
    assign count  = r_count;
    assign m_data = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_ack   <= 1'b0;
            r_count <= '0;
            r_level <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], r_i};
            if (w_accept) begin
                r_ack   <= ~r_ack;
                r_count <= r_count + CW'(1);
                r_wptr  <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; d_i is held by the sender until a_o toggles.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem[r_wptr] <= d_i;
        end
    end

endmodule
`default_nettype wire
